// File: rtl/residual_feed_ctrl.sv
// Residual add source sequencer: loads scales/shift, then streams paired
// words from SRAM A and B into the residual adder with element addresses.
module residual_feed_ctrl #(
    parameter int unsigned MAC_MULT_NUM    = 16,
    parameter int unsigned IDATA_WIDTH     = 8,
    parameter int unsigned SRAM_DEPTH      = 256,
    parameter int unsigned SRAM_RD_LATENCY = 2,
    parameter int unsigned SCALE_WIDTH     = 16,
    parameter int unsigned SHIFT_WIDTH     = 5,
    localparam int unsigned AW  = $clog2(SRAM_DEPTH),
    localparam int unsigned LW  = AW + 1,
    localparam int unsigned LGM = $clog2(MAC_MULT_NUM),
    localparam int unsigned OAW = AW + LGM,
    localparam int unsigned DW  = MAC_MULT_NUM * IDATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AW-1:0]          cfg_base_a,
    input  logic [AW-1:0]          cfg_base_b,
    input  logic [AW-1:0]          cfg_out_base,
    input  logic [LW-1:0]          cfg_len,
    input  logic [SCALE_WIDTH-1:0] cfg_scale_a,
    input  logic [SCALE_WIDTH-1:0] cfg_scale_b,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic                   rd_gnt,
    output logic                   sram_a_ren,
    output logic                   sram_b_ren,
    output logic [AW-1:0]          sram_a_raddr,
    output logic [AW-1:0]          sram_b_raddr,
    input  logic [DW-1:0]          sram_a_rdata,
    input  logic [DW-1:0]          sram_b_rdata,
    output logic                   scale_vld,
    output logic [SCALE_WIDTH-1:0] scale_a,
    output logic [SCALE_WIDTH-1:0] scale_b,
    output logic                   shift_vld,
    output logic [SHIFT_WIDTH-1:0] shift,
    output logic [DW-1:0]          out_data_a,
    output logic [DW-1:0]          out_data_b,
    output logic                   out_data_vld,
    output logic [OAW-1:0]         out_addr,
    output logic                   out_finish,
    output logic                   busy
);

    localparam int unsigned LAST = SRAM_RD_LATENCY - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CFG   = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [AW-1:0] out_base_q;
    logic [LW-1:0] len_q;
    logic [AW-1:0] idx;
    logic          accept;
    logic          last_idx;
    logic [AW-1:0] dst_word;

    logic [SRAM_RD_LATENCY-1:0] pipe_vld;
    logic [SRAM_RD_LATENCY-1:0] pipe_last;
    logic [AW-1:0]              pipe_idx [SRAM_RD_LATENCY];

    logic ren_d;
    logic busy_d;
    logic cfg_load_d;
    logic finish_d;

    assign accept   = sram_a_ren & rd_gnt;
    assign last_idx = (LW'(idx) == (len_q - LW'(1)));
    assign dst_word = out_base_q + pipe_idx[LAST];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_CFG;
            S_CFG:   next_state = (len_q == '0) ? S_DRAIN : S_ISSUE;
            S_ISSUE: if (accept && last_idx) next_state = S_DRAIN;
            S_DRAIN: if (out_finish) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode; values are registered below so they line up with the state they describe
    always_comb begin
        ren_d      = 1'b0;
        busy_d     = 1'b0;
        cfg_load_d = 1'b0;
        finish_d   = 1'b0;
        ren_d      = (next_state == S_ISSUE);
        busy_d     = (next_state != S_IDLE);
        cfg_load_d = (state == S_IDLE) && (next_state == S_CFG);
        finish_d   = ((state == S_CFG) && (len_q == '0)) || (pipe_vld[LAST] && pipe_last[LAST]);
    end

    // Issue counters, return tag pipeline and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_a_ren   <= 1'b0;
            sram_b_ren   <= 1'b0;
            sram_a_raddr <= '0;
            sram_b_raddr <= '0;
            scale_vld    <= 1'b0;
            scale_a      <= '0;
            scale_b      <= '0;
            shift_vld    <= 1'b0;
            shift        <= '0;
            out_data_a   <= '0;
            out_data_b   <= '0;
            out_data_vld <= 1'b0;
            out_addr     <= '0;
            out_finish   <= 1'b0;
            busy         <= 1'b0;
            out_base_q   <= '0;
            len_q        <= '0;
            idx          <= '0;
            pipe_vld     <= '0;
            pipe_last    <= '0;
            for (int unsigned i = 0; i < SRAM_RD_LATENCY; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            sram_a_ren <= ren_d;
            sram_b_ren <= ren_d;
            busy       <= busy_d;
            scale_vld  <= cfg_load_d;
            shift_vld  <= cfg_load_d;
            out_finish <= finish_d;

            if (cfg_load_d) begin
                scale_a      <= cfg_scale_a;
                scale_b      <= cfg_scale_b;
                shift        <= cfg_shift;
                sram_a_raddr <= cfg_base_a;
                sram_b_raddr <= cfg_base_b;
                out_base_q   <= cfg_out_base;
                len_q        <= cfg_len;
                idx          <= '0;
            end else if (accept) begin
                sram_a_raddr <= sram_a_raddr + AW'(1);
                sram_b_raddr <= sram_b_raddr + AW'(1);
                idx          <= idx + AW'(1);
            end

            // Tag rides alongside the SRAM access so data and address emerge together
            pipe_vld[0]  <= accept;
            pipe_last[0] <= accept & last_idx;
            pipe_idx[0]  <= idx;
            for (int unsigned i = 1; i < SRAM_RD_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_idx[i]  <= pipe_idx[i-1];
            end

            out_data_vld <= pipe_vld[LAST];
            if (pipe_vld[LAST]) begin
                out_data_a <= sram_a_rdata;
                out_data_b <= sram_b_rdata;
                out_addr   <= {dst_word, LGM'(0)};
            end
        end
    end

endmodule

// File: tb/tb_residual_feed_ctrl.sv
// Scoreboard bench for residual_feed_ctrl: SRAM model, random grants,
// expected streams computed from job parameters.
module tb_residual_feed_ctrl;

    localparam int L   = 2;
    localparam int D   = 256;
    localparam int M   = 16;
    localparam int AW  = 8;
    localparam int DW  = 128;
    localparam int OAW = 12;
    localparam int CW  = 336;
    localparam logic [DW-1:0] JUNK_A = {4{32'hDEAD_BEEF}};
    localparam logic [DW-1:0] JUNK_B = {4{32'hBAAD_F00D}};

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [AW-1:0]  cfg_base_a, cfg_base_b, cfg_out_base;
    logic [AW:0]    cfg_len;
    logic [15:0]    cfg_scale_a, cfg_scale_b;
    logic [4:0]     cfg_shift;
    logic           rd_gnt;
    logic           sram_a_ren, sram_b_ren;
    logic [AW-1:0]  sram_a_raddr, sram_b_raddr;
    logic [DW-1:0]  sram_a_rdata, sram_b_rdata;
    logic           scale_vld, shift_vld;
    logic [15:0]    scale_a, scale_b;
    logic [4:0]     shift;
    logic [DW-1:0]  out_data_a, out_data_b;
    logic           out_data_vld;
    logic [OAW-1:0] out_addr;
    logic           out_finish;
    logic           busy;

    residual_feed_ctrl #(.SRAM_RD_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b), .cfg_out_base(cfg_out_base),
        .cfg_len(cfg_len), .cfg_scale_a(cfg_scale_a), .cfg_scale_b(cfg_scale_b),
        .cfg_shift(cfg_shift), .rd_gnt(rd_gnt),
        .sram_a_ren(sram_a_ren), .sram_b_ren(sram_b_ren),
        .sram_a_raddr(sram_a_raddr), .sram_b_raddr(sram_b_raddr),
        .sram_a_rdata(sram_a_rdata), .sram_b_rdata(sram_b_rdata),
        .scale_vld(scale_vld), .scale_a(scale_a), .scale_b(scale_b),
        .shift_vld(shift_vld), .shift(shift),
        .out_data_a(out_data_a), .out_data_b(out_data_b), .out_data_vld(out_data_vld),
        .out_addr(out_addr), .out_finish(out_finish), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [OAW-1:0] addr;
        logic           last;
    } exp_t;

    typedef struct packed {
        logic [15:0] sa;
        logic [15:0] sb;
        logic [4:0]  sh;
    } cfg_t;

    exp_t exp_q[$];
    cfg_t cfg_q[$];
    int   ra_q[$];
    int   rb_q[$];
    int   lat_q[$];
    int   fin0_q[$];

    logic [DW-1:0] mem_a [D];
    logic [DW-1:0] mem_b [D];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int gnt_mode = 0;
    int issue_cyc = 0;
    logic prev_fin = 1'b0;
    logic prev_cfg = 1'b0;

    task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // SRAM model: returns data L cycles after each accepted read, regardless of DUT reset
    logic [L-1:0]  line_v;
    logic [AW-1:0] line_a [L];
    logic [AW-1:0] line_b [L];
    always @(posedge clk) begin
        line_v[0] <= sram_a_ren & rd_gnt;
        line_a[0] <= sram_a_raddr;
        line_b[0] <= sram_b_raddr;
        for (int i = 1; i < L; i++) begin
            line_v[i] <= line_v[i-1];
            line_a[i] <= line_a[i-1];
            line_b[i] <= line_b[i-1];
        end
    end
    assign sram_a_rdata = line_v[L-1] ? mem_a[line_a[L-1]] : JUNK_A;
    assign sram_b_rdata = line_v[L-1] ? mem_b[line_b[L-1]] : JUNK_B;

    // Grant generator: always, random, or low on ISSUE cycles 2 and 3
    always @(negedge clk) begin
        if (sram_a_ren) issue_cyc++;
        else            issue_cyc = 0;
        case (gnt_mode)
            0:       rd_gnt = 1'b1;
            1:       rd_gnt = ($urandom_range(0, 3) != 0);
            default: rd_gnt = !(issue_cyc == 2 || issue_cyc == 3);
        endcase
    end

    // Monitor
    logic          m_r, m_ren, m_acc;
    logic [AW-1:0] m_ra, m_rb;
    exp_t          e;
    cfg_t          c;
    int            k;
    always @(posedge clk) begin
        m_r   = rst;
        m_ren = sram_a_ren;
        m_acc = sram_a_ren & rd_gnt;
        m_ra  = sram_a_raddr;
        m_rb  = sram_b_raddr;
        cyc++;
        #1;
        if (m_r) begin
            check("reset_outputs", CW'({sram_a_ren, sram_b_ren, sram_a_raddr, sram_b_raddr,
                  scale_vld, scale_a, scale_b, shift_vld, shift, out_data_a, out_data_b,
                  out_data_vld, out_addr, out_finish, busy}), '0);
            exp_q.delete(); cfg_q.delete(); ra_q.delete(); rb_q.delete();
            lat_q.delete(); fin0_q.delete();
            prev_fin = 1'b0;
            prev_cfg = 1'b0;
        end else begin
            if (m_ren) begin
                check("ren_expected", CW'(ra_q.size() > 0), CW'(1));
                if (ra_q.size() > 0) begin
                    check("raddr_a", CW'(m_ra), CW'(ra_q[0]));
                    check("raddr_b", CW'(m_rb), CW'(rb_q[0]));
                    if (m_acc) begin
                        void'(ra_q.pop_front());
                        void'(rb_q.pop_front());
                        lat_q.push_back(cyc);
                    end
                end
            end
            check("ren_pair", CW'(sram_b_ren), CW'(sram_a_ren));
            if (scale_vld) begin
                check("cfg_expected", CW'(cfg_q.size() > 0), CW'(1));
                if (cfg_q.size() > 0) begin
                    c = cfg_q.pop_front();
                    check("scale_a", CW'(scale_a), CW'(c.sa));
                    check("scale_b", CW'(scale_b), CW'(c.sb));
                    check("shift", CW'(shift), CW'(c.sh));
                end
                check("shift_vld", CW'(shift_vld), CW'(scale_vld));
                check("busy_in_cfg", CW'(busy), CW'(1));
            end
            if (out_data_vld) begin
                check("vld_expected", CW'(exp_q.size() > 0), CW'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("data_a", CW'(out_data_a), CW'(e.a));
                    check("data_b", CW'(out_data_b), CW'(e.b));
                    check("out_addr", CW'(out_addr), CW'(e.addr));
                    check("finish_flag", CW'(out_finish), CW'(e.last));
                end
                check("accept_recorded", CW'(lat_q.size() > 0), CW'(1));
                if (lat_q.size() > 0) begin
                    k = lat_q.pop_front();
                    check("latency", CW'(cyc + 1 - k), CW'(L + 1));
                end
            end else if (out_finish) begin
                check("fin0_expected", CW'(fin0_q.size() > 0), CW'(1));
                if (fin0_q.size() > 0) void'(fin0_q.pop_front());
                check("fin0_after_cfg", CW'(prev_cfg), CW'(1));
            end
            if (prev_fin) check("busy_drop", CW'(busy), CW'(0));
            if (out_finish) begin
                check("busy_at_finish", CW'(busy), CW'(1));
                done_cnt++;
            end
            prev_fin = out_finish;
            prev_cfg = scale_vld;
        end
    end

    task automatic run_job(input int ba, input int bb, input int ob, input int ln,
                           input int sa, input int sb, input int sh, input bit expect_it);
        @(negedge clk);
        cfg_base_a   = AW'(ba);
        cfg_base_b   = AW'(bb);
        cfg_out_base = AW'(ob);
        cfg_len      = 9'(ln);
        cfg_scale_a  = 16'(sa);
        cfg_scale_b  = 16'(sb);
        cfg_shift    = 5'(sh);
        start        = 1'b1;
        if (expect_it) begin
            cfg_q.push_back('{sa: 16'(sa), sb: 16'(sb), sh: 5'(sh)});
            if (ln == 0) fin0_q.push_back(1);
            for (int i = 0; i < ln; i++) begin
                ra_q.push_back((ba + i) % D);
                rb_q.push_back((bb + i) % D);
                exp_q.push_back('{a: mem_a[(ba + i) % D], b: mem_b[(bb + i) % D],
                                  addr: OAW'(((ob + i) % D) * M), last: (i == ln - 1)});
            end
        end
        @(negedge clk);
        start        = 1'b0;
        cfg_base_a   = AW'($urandom);
        cfg_base_b   = AW'($urandom);
        cfg_out_base = AW'($urandom);
        cfg_len      = 9'($urandom);
        cfg_scale_a  = 16'($urandom);
        cfg_scale_b  = 16'($urandom);
        cfg_shift    = 5'($urandom);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("job_done", CW'(done_cnt), CW'(target));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_base_a = '0; cfg_base_b = '0; cfg_out_base = '0; cfg_len = '0;
        cfg_scale_a = '0; cfg_scale_b = '0; cfg_shift = '0;
        for (int i = 0; i < D; i++) begin
            mem_a[i] = {$urandom, $urandom, $urandom, $urandom};
            mem_b[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        gnt_mode = 0;
        run_job(0, 64, 8, 4, 3, 5, 4, 1);
        wait_done(1);

        gnt_mode = 2;
        run_job(10, 20, 30, 6, 7, 9, 11, 1);
        wait_done(2);

        gnt_mode = 0;
        run_job(254, 255, 255, 3, 100, 200, 31, 1);
        wait_done(3);

        run_job(5, 6, 7, 0, 1000, 2000, 17, 1);
        wait_done(4);

        // Second start while busy must be ignored
        gnt_mode = 1;
        run_job(40, 50, 60, 10, 11, 22, 3, 1);
        repeat (3) @(negedge clk);
        run_job(1, 2, 3, 5, 9, 9, 9, 0);
        wait_done(5);

        // Reset with reads in flight, start coincident with reset
        gnt_mode = 0;
        run_job(100, 110, 120, 12, 44, 55, 6, 1);
        repeat (4) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("no_finish_after_reset", CW'(done_cnt), CW'(5));

        run_job(30, 31, 32, 5, 12, 34, 2, 1);
        wait_done(6);

        gnt_mode = 1;
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(0, D - 1), $urandom_range(0, D - 1), $urandom_range(0, D - 1),
                    $urandom_range(1, 20), $urandom_range(0, 65535), $urandom_range(0, 65535),
                    $urandom_range(0, 31), 1);
            wait_done(7 + j);
        end

        run_job($urandom_range(0, D - 1), $urandom_range(0, D - 1), $urandom_range(0, D - 1),
                D, 321, 654, 19, 1);
        wait_done(13);

        repeat (5) @(negedge clk);
        check("exp_drained", CW'(exp_q.size()), CW'(0));
        check("raddr_drained", CW'(ra_q.size()), CW'(0));
        check("cfg_drained", CW'(cfg_q.size()), CW'(0));
        check("idle_at_end", CW'(busy), CW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

endmodule
